// File: rtl/ip_lookup_pkg.sv
// ip_lookup_pkg
// Shared types and constants for the output-port lookup issue stage.
//   KEY_W / LUT_DATA_W : default key and LUT result widths of the router.
//   DMASK_EXACT        : per-bit don't-care value driven to the CAM (0 = compare bit).
//   lookup_result_t    : one ordered lookup result {key, hit, data}.
package ip_lookup_pkg;

  localparam int KEY_W      = 32;
  localparam int LUT_DATA_W = 3;

  localparam logic DMASK_EXACT = 1'b0;

  typedef struct packed {
    logic [KEY_W-1:0]      key;
    logic                  hit;
    logic [LUT_DATA_W-1:0] data;
  } lookup_result_t;

endpackage

// File: rtl/ip_lookup_issue_fifo.sv
// small_fifo_sync
// Synchronous FIFO with occupancy count and a flush that keeps a same-cycle push.
//   clk, reset    : clock, asynchronous active-low reset
//   flush         : discard all entries (a simultaneous push becomes the only entry)
//   push/push_data: write; ignored when full and not flushing
//   pop           : advance the head; ignored when empty
//   pop_data      : head entry, 0 while empty (no fall-through)
//   count         : number of stored entries, 0..DEPTH
module small_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign wr_en   = flush ? push : do_push;
  assign wr_idx  = flush ? '0 : wr_ptr;

  // Gated so the outputs read 0 while empty, regardless of stale storage.
  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= CW'(push);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never visible and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/ip_lookup_issue.sv
// ip_lookup_issue
// Issues destination keys into the CAM/LUT lookup port at up to one per clock,
// tracks in-flight lookups, and queues ordered hit/miss results.
//   req_valid/req_key/req_ready     : key input from the header parser
//   lookup_req/cmp_data/cmp_dmask   : issue pulse and key to the LUT
//   lookup_ack/lookup_hit/lookup_data: in-order result from the LUT
//   wr_pending                      : LUT register write waiting; forces idle gaps
//   res_valid/res_key/res_hit/res_data, res_rd : result FIFO head and pop
//   err_timeout                     : sticky, an ack never came back
//   stat_hit/stat_miss              : one pulse per result pushed
module ip_lookup_issue
  import ip_lookup_pkg::*;
#(
  parameter int CMP_WIDTH    = KEY_W,
  parameter int DATA_WIDTH   = LUT_DATA_W,
  parameter int RESULT_DEPTH = 4,
  parameter int MAX_BURST    = 8,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [CMP_WIDTH-1:0]  req_key,
  output logic                  req_ready,
  output logic                  lookup_req,
  output logic [CMP_WIDTH-1:0]  lookup_cmp_data,
  output logic [CMP_WIDTH-1:0]  lookup_cmp_dmask,
  input  logic                  lookup_ack,
  input  logic                  lookup_hit,
  input  logic [DATA_WIDTH-1:0] lookup_data,
  input  logic                  wr_pending,
  output logic                  res_valid,
  output logic [CMP_WIDTH-1:0]  res_key,
  output logic                  res_hit,
  output logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_rd,
  output logic                  err_timeout,
  output logic                  stat_hit,
  output logic                  stat_miss
);

  localparam int CNT_W   = $clog2(RESULT_DEPTH) + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam int RES_W   = CMP_WIDTH + 1 + DATA_WIDTH;

  logic               rdy_en;
  logic [CNT_W-1:0]   in_flight;
  logic [CNT_W-1:0]   res_count;
  logic [SUM_W-1:0]   credit_used;
  logic [BURST_W-1:0] burst_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               issue;
  logic               accept;
  logic               ack_ok;
  logic               gap;
  logic               timeout;
  logic [CMP_WIDTH-1:0] tag_head;
  logic [RES_W-1:0]     res_word;

  assign lookup_cmp_dmask = {CMP_WIDTH{DMASK_EXACT}};

  // The registered issue pulse is the cycle the LUT sees the key.
  assign issue  = lookup_req;
  // Acks with nothing outstanding (after a timeout flush or a reset) are dropped.
  assign ack_ok = lookup_ack && (in_flight != '0);

  // Blocks the accept that would become the (MAX_BURST+1)-th back-to-back
  // issue, so the LUT gets one idle cycle for the pending register write.
  assign gap = wr_pending && issue && (burst_cnt == BURST_W'(MAX_BURST - 1));

  // Keys accepted but not yet issued count too, so the result FIFO can never overflow.
  assign credit_used = SUM_W'(in_flight) + SUM_W'(res_count) + SUM_W'(issue);
  assign req_ready   = rdy_en && (credit_used < SUM_W'(RESULT_DEPTH)) && !gap;
  assign accept      = req_valid && req_ready;

  assign timeout = !lookup_ack && (in_flight != '0) && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  assign stat_hit  = ack_ok && lookup_hit;
  assign stat_miss = ack_ok && !lookup_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en          <= 1'b0;
      lookup_req      <= 1'b0;
      lookup_cmp_data <= '0;
      burst_cnt       <= '0;
      to_cnt          <= '0;
      err_timeout     <= 1'b0;
    end else begin
      rdy_en     <= 1'b1;
      lookup_req <= accept;
      if (accept) lookup_cmp_data <= req_key;

      if (gap || !issue || !wr_pending) burst_cnt <= '0;
      else                              burst_cnt <= burst_cnt + BURST_W'(1);

      if (ack_ok || (in_flight == '0) || timeout) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + TO_W'(1);

      if (timeout) err_timeout <= 1'b1;
    end
  end

  // Tag queue: its occupancy is exactly the in-flight count, since it is pushed
  // on issue, popped on a counted ack and flushed on timeout.
  small_fifo_sync #(
    .WIDTH (CMP_WIDTH),
    .DEPTH (RESULT_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (timeout),
    .push      (issue),
    .push_data (lookup_cmp_data),
    .pop       (ack_ok),
    .pop_data  (tag_head),
    .count     (in_flight)
  );

  small_fifo_sync #(
    .WIDTH (RES_W),
    .DEPTH (RESULT_DEPTH)
  ) u_res_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (ack_ok),
    .push_data ({tag_head, lookup_hit, lookup_data}),
    .pop       (res_rd),
    .pop_data  (res_word),
    .count     (res_count)
  );

  assign res_valid = (res_count != '0);
  assign {res_key, res_hit, res_data} = res_word;

endmodule

// File: doc/ip_lookup_issue.md
# ip_lookup_issue

Upstream request stage for the CAM-based output-port lookup in the router's output port lookup path. It takes destination IP addresses from the header parser and issues them back-to-back into the CAM/LUT lookup interface. It tracks in-flight lookups against the LUT's fixed pipeline latency and collects ordered hit/miss results in a small result FIFO for the port-select stage. It also inserts idle gaps so that pending register writes to the LUT are never starved by continuous lookups.

## Interface
Parameters:
- CMP_WIDTH, 32: lookup key width (destination IP).
- DATA_WIDTH, 3: LUT result width.
- RESULT_DEPTH, 4: result FIFO depth, power of two, ≥ 4.
- MAX_BURST, 8: maximum consecutive issue cycles while `wr_pending` is high.
- ACK_TIMEOUT, 15: cycles to wait for a lookup ack before flagging an error.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  key offered by the header parser.
- req_key  in  CMP_WIDTH  destination IP.
- req_ready  out  1  key accepted when `req_valid & req_ready`.
- lookup_req  out  1  one-cycle issue pulse to the LUT.
- lookup_cmp_data  out  CMP_WIDTH  key; registered, held until the next issue.
- lookup_cmp_dmask  out  CMP_WIDTH  constant 0 (exact compare of every key bit).
- lookup_ack  in  1  result valid pulse from the LUT.
- lookup_hit  in  1  qualifies `lookup_ack`.
- lookup_data  in  DATA_WIDTH  qualifies `lookup_ack`.
- wr_pending  in  1  a register write to the LUT is waiting.
- res_valid  out  1  FIFO non-empty.
- res_key  out  CMP_WIDTH  key of the head result.
- res_hit  out  1  hit flag of the head result.
- res_data  out  DATA_WIDTH  LUT data of the head result.
- res_rd  in  1  pops the head result; ignored when empty.
- err_timeout  out  1  sticky error flag; cleared only by reset.
- stat_hit  out  1  one-cycle pulse per hit result pushed.
- stat_miss  out  1  one-cycle pulse per miss result pushed.

## Operation
- Issue: on accept, register `req_key` into `lookup_cmp_data` and pulse `lookup_req` in the following cycle. At most one issue per cycle; full throughput is 1 key/clk.
- Key tag FIFO: each issued key is also written into an internal tag queue of depth RESULT_DEPTH. Acks return strictly in issue order. On `lookup_ack` the head tag is popped and {key, `lookup_hit`, `lookup_data`} is pushed into the result FIFO.
- Credit: `in_flight` counts keys issued and not yet acked, in the range 0..RESULT_DEPTH.
  - `req_ready = (in_flight + res_count + issue_pending) < RESULT_DEPTH && !gap`.
  - A result FIFO overflow is therefore impossible by construction.
- Write-starvation guard: `burst_cnt` increments on each issue cycle while `wr_pending=1`.
  - On reaching MAX_BURST, `gap` is set for exactly one cycle, forcing `req_ready=0` so the LUT sees a cycle with no lookup.
  - `burst_cnt` clears on the gap cycle, on any non-issue cycle, or when `wr_pending=0`.
- Timeout: `to_cnt` counts cycles while `in_flight>0` with no ack, and resets on every ack.
  - On reaching ACK_TIMEOUT: set `err_timeout`, flush the tag queue, and set `in_flight=0`.
  - No result is pushed for the lost keys.
  - A late ack arriving when `in_flight==0` is dropped.
- Simultaneous events:
  - Issue and ack in the same cycle leaves `in_flight` unchanged.
  - Push and pop in the same cycle on a non-empty FIFO leaves the count unchanged.
  - Pop on empty is ignored.

## Timing
- Reset values: `req_ready=0` during reset and 1 in the first cycle after release. `lookup_req=0`, `lookup_cmp_data=0`, `res_valid=0`, res_* outputs 0, `err_timeout=0`, `stat_*=0`. All counters are 0.
- Accept at cycle T → `lookup_req` high in T+1.
- LUT ack arrives at T+4, since the LUT adds 3 cycles. The result is pushed in T+4 and `res_valid` is high in T+5, giving 5 cycles from accept to result visible.
- `stat_hit`/`stat_miss` are asserted in the push cycle.
- FIFO outputs are registered from storage with no fall-through; `res_*` are stable while `res_valid=1 & !res_rd`.
- Reset asserted mid-operation clears everything asynchronously. In-flight acks arriving after reset release are dropped by the `in_flight==0` rule.

## Structure
- Shared package `ip_lookup_pkg`: result record type {key, hit, data}, and the constant DMASK_EXACT=0.
- Natural sub-module: `small_fifo_sync`, a synchronous FIFO with count output. It is instantiated twice: once as the tag queue (CMP_WIDTH wide) and once as the result FIFO (CMP_WIDTH+1+DATA_WIDTH wide).
- The credit counter, burst counter and timeout counter live in the top level.

## Test plan
- Single key 0x0A000001, LUT model hit with data 3 → `lookup_req` at T+1; `res_valid` at T+5 with res_key 0x0A000001, res_hit=1, res_data=3; `stat_hit` pulse.
- 16 back-to-back keys with `res_rd` held high, alternating hit/miss → 16 results in order, hits/misses alternating, `stat_hit`=8, `stat_miss`=8.
- `res_rd=0` with continuous `req_valid` (RESULT_DEPTH=4) → exactly 4 accepts, then `req_ready=0`. One pop → one more accept.
- `wr_pending=1` with continuous requests, MAX_BURST=8 → after every 8 `lookup_req` pulses exactly one idle cycle occurs. With `wr_pending=0` there are no gaps.
- LUT model drops the ack for key #2 of 3 → `err_timeout=1` 15 cycles after the last ack, `in_flight=0`, and `req_ready` recovers.
- Reset asserted one cycle after 3 issues → all outputs at reset values. Late acks are ignored, with no `res_valid`.
